// File: rtl/bus_sequencer.sv
// Multicycle sequencer that shares one Avalon-style memory port between instruction
// fetch and a single data load/store per instruction, with a stalled-bus watchdog.
module bus_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc,
  input  logic        mem_read_req,
  input  logic        mem_write_req,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byteen,
  input  logic        halt_req,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic [31:0] instr_word,
  output logic [31:0] load_data,
  output logic        exec_stage,
  output logic        mem_stage,
  output logic        pc_en,
  output logic        load_valid,
  output logic        active,
  output logic        bus_error
);

  // A zero timeout disables the watchdog; keep the counter at least one bit wide.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] StFetch  = 2'd0;
  localparam logic [1:0] StExec   = 2'd1;
  localparam logic [1:0] StMem    = 2'd2;
  localparam logic [1:0] StHalted = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            is_store_q, is_store_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     instr_word_q, load_data_q;
  logic            load_valid_q, bus_error_q;

  logic            bus_read, bus_write, pc_en_c, stall, wd_trip;
  logic [31:0]     addr_mux;
  logic [3:0]      be_mux;

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    bus_read   = 1'b0;
    bus_write  = 1'b0;
    addr_mux   = pc;
    be_mux     = 4'b0000;
    pc_en_c    = 1'b0;
    unique case (state_q)
      StFetch: begin
        bus_read = 1'b1;
        be_mux   = 4'b1111;
        if (!waitrequest) state_d = StExec;
      end
      StExec: begin
        if (halt_req) begin
          state_d = StHalted;
        end else if (mem_read_req || mem_write_req) begin
          state_d    = StMem;
          is_store_d = mem_write_req;
        end else begin
          pc_en_c = 1'b1;
          state_d = StFetch;
        end
      end
      StMem: begin
        addr_mux  = mem_addr;
        be_mux    = mem_byteen;
        bus_write = is_store_q;
        bus_read  = !is_store_q;
        if (!waitrequest) begin
          pc_en_c = 1'b1;
          state_d = StFetch;
        end
      end
      default: ;
    endcase

    stall   = (bus_read || bus_write) && waitrequest;
    cnt_d   = stall ? cnt_q + CntW'(1) : '0;
    // Trip on the stalled cycle that brings the run of stalls up to the timeout.
    wd_trip = (TIMEOUT_CYCLES != 0) && stall && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    if (wd_trip) state_d = StHalted;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StFetch;
      is_store_q   <= 1'b0;
      cnt_q        <= '0;
      instr_word_q <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      cnt_q        <= cnt_d;
      load_valid_q <= (state_q == StMem) && !is_store_q && !waitrequest;
      if (state_q == StFetch && !waitrequest) instr_word_q <= readdata;
      if (state_q == StMem && !is_store_q && !waitrequest) load_data_q <= readdata;
      if (wd_trip) bus_error_q <= 1'b1;
    end
  end

  // Strobes and stage flags are gated by reset so an in-flight cycle is dropped at once.
  assign address    = addr_mux;
  assign read       = reset_n && bus_read;
  assign write      = reset_n && bus_write;
  assign byteenable = reset_n ? be_mux : 4'b0000;
  assign writedata  = write ? mem_wdata : 32'h0;
  assign pc_en      = reset_n && pc_en_c;
  assign exec_stage = reset_n && (state_q == StExec);
  assign mem_stage  = reset_n && (state_q == StMem);
  assign active     = reset_n && (state_q != StHalted);
  assign instr_word = instr_word_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench: a program-level model expands each instruction into its expected
// per-cycle bus trace, which is replayed against the DUT cycle by cycle.
module tb_bus_sequencer;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc, mem_addr, mem_wdata, readdata;
  logic        mem_read_req, mem_write_req, halt_req, waitrequest;
  logic [3:0]  mem_byteen;
  logic [31:0] address, writedata, instr_word, load_data;
  logic        read, write, exec_stage, mem_stage, pc_en, load_valid, active, bus_error;
  logic [3:0]  byteenable;

  bus_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
    .halt_req(halt_req), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest), .instr_word(instr_word), .load_data(load_data),
    .exec_stage(exec_stage), .mem_stage(mem_stage), .pc_en(pc_en),
    .load_valid(load_valid), .active(active), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstn, wr, rq, wq, hq;
    logic [31:0] pc, rdata, maddr, wdata;
    logic [3:0]  be;
    logic [31:0] e_addr, e_wd, e_iw, e_ld;
    logic [3:0]  e_be;
    logic        e_rd, e_wr, e_ex, e_mem, e_pcen, e_act, e_lv, e_err;
  } cyc_t;

  cyc_t q[$];

  // Architectural view held by the model while the trace is built.
  logic [31:0] m_iw, m_ld;
  logic        m_lv, m_err;
  logic [31:0] c_pc, c_maddr, c_wdata;
  logic [3:0]  c_be;
  logic        c_rq, c_wq, c_hq;

  int n_vec = 0, n_err = 0, cur_i = 0;
  int t1, t_ld, t_ld_end, t_st, t_h, t_wd, t_r;

  function automatic cyc_t base();
    cyc_t c;
    c.rstn = 1'b1; c.wr = 1'b0; c.rq = c_rq; c.wq = c_wq; c.hq = c_hq;
    c.pc = c_pc; c.rdata = 32'h5A5A_0F0F; c.maddr = c_maddr; c.wdata = c_wdata; c.be = c_be;
    c.e_addr = 32'h0; c.e_wd = 32'h0; c.e_iw = 32'h0; c.e_ld = 32'h0; c.e_be = 4'h0;
    c.e_rd = 1'b0; c.e_wr = 1'b0; c.e_ex = 1'b0; c.e_mem = 1'b0; c.e_pcen = 1'b0;
    c.e_act = 1'b1; c.e_lv = 1'b0; c.e_err = 1'b0;
    return c;
  endfunction

  task automatic push(input cyc_t c);
    c.e_iw = m_iw; c.e_ld = m_ld; c.e_lv = m_lv; c.e_err = m_err;
    q.push_back(c);
    m_lv = 1'b0;
  endtask

  task automatic add_reset(input int n);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      c = base(); c.rstn = 1'b0; c.wr = 1'b1; c.e_act = 1'b0;
      push(c);
      m_iw = 32'h0; m_ld = 32'h0; m_lv = 1'b0; m_err = 1'b0;
    end
  endtask

  task automatic add_halted(input int n, input logic wr);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      c = base(); c.wr = wr; c.e_act = 1'b0;
      push(c);
    end
  endtask

  // kind: 0 plain, 1 load, 2 store, 3 halt. cut>0 stops the trace after cut MEM cycles.
  task automatic add_instr(input logic [31:0] ipc, word, input int fw, kind,
                           input logic [31:0] maddr, wdata, input logic [3:0] be,
                           input int mw, input logic [31:0] rdata, input int cut);
    cyc_t c;
    c_pc = ipc; c_maddr = maddr; c_wdata = wdata; c_be = be;
    c_rq = (kind == 1); c_wq = (kind == 2); c_hq = (kind == 3);
    for (int k = 0; k <= fw; k++) begin
      c = base(); c.wr = (k < fw);
      c.rdata = (k == fw) ? word : 32'hBAD0_0000 + 32'(k);
      c.e_addr = ipc; c.e_rd = 1'b1; c.e_be = 4'hF;
      push(c);
      if (k == fw) m_iw = word;
    end
    c = base(); c.wr = 1'b1; c.e_ex = 1'b1; c.e_pcen = (kind == 0);
    push(c);
    if (kind == 1 || kind == 2) begin
      for (int k = 0; k <= mw; k++) begin
        if (cut > 0 && k == cut) return;
        c = base(); c.wr = (k < mw);
        c.rdata = (kind == 1 && k == mw) ? rdata : 32'hC0DE_0000 + 32'(k);
        c.e_addr = maddr; c.e_be = be; c.e_rd = (kind == 1); c.e_wr = (kind == 2);
        c.e_wd = (kind == 2) ? wdata : 32'h0; c.e_mem = 1'b1; c.e_pcen = (k == mw);
        push(c);
        if (kind == 1 && k == mw) begin m_ld = rdata; m_lv = 1'b1; end
      end
    end
  endtask

  task automatic add_stuck(input logic [31:0] ipc, input int n_after);
    cyc_t c;
    c_pc = ipc; c_rq = 1'b0; c_wq = 1'b0; c_hq = 1'b0;
    for (int k = 0; k < int'(TO); k++) begin
      c = base(); c.wr = 1'b1; c.e_addr = ipc; c.e_rd = 1'b1; c.e_be = 4'hF;
      push(c);
    end
    m_err = 1'b1;
    add_halted(n_after, 1'b1);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h, expected %h", nm, cur_i, act, exp);
    end
  endtask

  initial begin
    int pe_cnt, lv_cnt, hold_cnt, st_cnt, act_cnt;
    cyc_t c;
    pe_cnt = 0; lv_cnt = 0; hold_cnt = 0; st_cnt = 0; act_cnt = 0;
    m_iw = 0; m_ld = 0; m_lv = 0; m_err = 0;
    c_pc = 0; c_maddr = 0; c_wdata = 0; c_be = 0; c_rq = 0; c_wq = 0; c_hq = 0;

    t1 = q.size();
    add_instr(32'hBFC0_0000, 32'h0022_1820, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    t_ld = q.size();
    add_instr(32'hBFC0_0004, 32'h8C01_0000, 1, 1, 32'h0000_1000, 0, 4'hF, 3, 32'hDEAD_BEEF, 0);
    t_ld_end = q.size();
    add_instr(32'hBFC0_0008, 32'hAC02_0000, 0, 2, 32'h0000_2000, 32'h1234_5678, 4'b0011, 0, 0, 0);
    t_st = q.size() - 1;
    add_instr(32'hBFC0_000C, 32'h0043_2020, 7, 0, 0, 0, 4'h0, 0, 0, 0);
    add_instr(32'hBFC0_0010, 32'h8C03_0004, 0, 1, 32'h0000_1004, 0, 4'b1100, 0, 32'h0BAD_F00D, 0);
    add_instr(32'hBFC0_0014, 32'h0000_000D, 0, 3, 0, 0, 4'h0, 0, 0, 0);
    t_h = q.size();
    add_halted(20, 1'b0);
    add_reset(1);
    t_wd = q.size();
    add_stuck(32'h0000_0000, 5);
    add_reset(1);
    add_instr(32'h0000_0100, 32'h0000_1111, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    add_instr(32'h0000_0104, 32'hAC00_0000, 0, 2, 32'h0000_3000, 32'hAAAA_5555, 4'hF, 5, 0, 2);
    t_r = q.size();
    add_reset(1);
    add_instr(32'h0000_0108, 32'h0000_2222, 0, 0, 0, 0, 4'h0, 0, 0, 0);

    reset_n = 1'b0; pc = 0; mem_read_req = 0; mem_write_req = 0; halt_req = 0;
    mem_addr = 0; mem_wdata = 0; mem_byteen = 0; readdata = 0; waitrequest = 0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < q.size(); i++) begin
      c = q[i];
      @(negedge clk);
      reset_n = c.rstn; pc = c.pc; readdata = c.rdata; waitrequest = c.wr;
      mem_read_req = c.rq; mem_write_req = c.wq; halt_req = c.hq;
      mem_addr = c.maddr; mem_wdata = c.wdata; mem_byteen = c.be;
      #1;
      cur_i = i;
      chk("read", read, c.e_rd);
      chk("write", write, c.e_wr);
      if (c.e_rd || c.e_wr) begin
        chk("address", address, c.e_addr);
        chk("byteenable", byteenable, c.e_be);
      end
      chk("writedata", writedata, c.e_wd);
      chk("exec_stage", exec_stage, c.e_ex);
      chk("mem_stage", mem_stage, c.e_mem);
      chk("pc_en", pc_en, c.e_pcen);
      chk("active", active, c.e_act);
      chk("instr_word", instr_word, c.e_iw);
      chk("load_data", load_data, c.e_ld);
      chk("load_valid", load_valid, c.e_lv);
      chk("bus_error", bus_error, c.e_err);

      // Hand-computed anchors for the directed scenarios.
      if (i == t1) begin
        chk("t1_read", read, 1); chk("t1_addr", address, 32'hBFC0_0000);
      end
      if (i == t1 + 1) begin
        chk("t1_iw", instr_word, 32'h0022_1820); chk("t1_exec", exec_stage, 1);
        chk("t1_pcen", pc_en, 1);
      end
      if (i == t1 + 2) chk("t1_refetch", read, 1);
      if (i >= t_ld && i <= t_ld_end) begin
        pe_cnt += int'(pc_en); lv_cnt += int'(load_valid);
        hold_cnt += int'(read && address == 32'h0000_1000);
      end
      if (i == t_ld_end) begin
        chk("ld_pcen_pulses", pe_cnt, 1); chk("ld_valid_pulses", lv_cnt, 1);
        chk("ld_hold_cycles", hold_cnt, 4); chk("ld_data", load_data, 32'hDEAD_BEEF);
      end
      if (i == t_st) begin
        chk("st_write", write, 1); chk("st_read", read, 0); chk("st_be", byteenable, 4'b0011);
        chk("st_wdata", writedata, 32'h1234_5678); chk("st_pcen", pc_en, 1);
      end
      if (i == t_h - 1) chk("halt_pcen", pc_en, 0);
      if (i >= t_h && i < t_h + 20) begin
        st_cnt += int'(read || write); act_cnt += int'(active);
      end
      if (i == t_h + 19) begin
        chk("halt_strobes", st_cnt, 0); chk("halt_active", act_cnt, 0);
      end
      if (i == t_wd + int'(TO) - 1) begin
        chk("wd_read_pre", read, 1); chk("wd_err_pre", bus_error, 0);
      end
      if (i == t_wd + int'(TO)) begin
        chk("wd_err", bus_error, 1); chk("wd_read_post", read, 0); chk("wd_active", active, 0);
      end
      if (i == t_r) chk("rst_write", write, 0);
      if (i == t_r + 1) begin
        chk("rst_iw", instr_word, 0); chk("rst_read", read, 1);
        chk("rst_addr", address, 32'h0000_0108);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
